// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and debounces
// whole-matrix frames into a single hex key code with a valid strobe.
//
// Ports:
//   CLK       system clock, rising edge
//   RESET     synchronous active-high reset
//   row[3:0]  row sense lines, active-low (pulled up)
//   col[3:0]  column drive, active-low one-hot
//   key_code  last accepted key, row*4+col
//   key_valid one-cycle pulse on each accepted press
//   key_held  high from acceptance until the release is debounced
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [DW-1:0] div;
    logic [1:0]    cidx;
    logic [15:0]   snap;
    logic [1:0]    state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;

    logic          step;
    logic          frame_end;
    logic [15:0]   frame;
    logic [4:0]    nbits;
    logic [3:0]    kidx;
    logic          is_none;
    logic          is_single;
    logic [CW-1:0] cnt_inc;

    // frame is the snapshot with the current column's rows merged in,
    // so the frame-end edge sees all 16 keys including column 3.
    always_comb begin
        step      = (div == DIV_LAST);
        frame_end = step && (cidx == 2'd3);
        frame     = snap;
        for (int r = 0; r < 4; r++) begin
            frame[{2'(r), cidx}] = ~row[r];
        end
        nbits = '0;
        kidx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                nbits = nbits + 5'd1;
                kidx  = 4'(i);
            end
        end
        is_none   = (nbits == 5'd0);
        is_single = (nbits == 5'd1);
        cnt_inc   = cnt + CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div       <= '0;
            cidx      <= '0;
            col       <= 4'b1110;
            snap      <= '0;
            state     <= S_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;

            if (step) begin
                div  <= '0;
                cidx <= cidx + 2'd1;
                col  <= ~(4'b0001 << (cidx + 2'd1));
                snap <= frame;
            end else begin
                div <= div + DIV_ONE;
            end

            if (frame_end) begin
                unique case (state)
                    S_IDLE: begin
                        if (is_single) begin
                            cand <= kidx;
                            cnt  <= CNT_ONE;
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_code  <= kidx;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= S_PRESSED;
                            end else begin
                                state <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (is_single && kidx == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= S_PRESSED;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        // single-frame debounce releases on the first
                        // empty frame, mirroring the press side
                        if (is_none) begin
                            cnt <= CNT_ONE;
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_held <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (is_none) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                key_held <= 1'b0;
                                state    <= S_IDLE;
                            end
                        end else begin
                            state <= S_PRESSED;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
